// File: rtl/writeback_queue.sv
// writeback_queue: in-order pending-write FIFO between the load/ALU result
// producers and the single register-file write port, with a decode-side
// forwarding lookup over all pending entries.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_valid/mem_rd/mem_data  load-unit result offer (fixed priority)
//   mem_ready                  load offer accepted this cycle
//   alu_valid/alu_rd/alu_data  ALU result offer
//   alu_ready                  ALU offer accepted this cycle
//   wb_stall                   register-file write port busy; hold head
//   we/rd/wd                   register-file write port
//   fwd_rs                     register looked up by decode
//   fwd_hit/fwd_data           youngest pending value for fwd_rs
//   count                      number of pending entries
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     wb_stall,
    output logic                     we,
    output logic [4:0]               rd,
    output logic [31:0]              wd,
    input  logic [4:0]               fwd_rs,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    // Pointer / occupancy state
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage; contents are don't-care while not valid
    logic [RW-1:0] entry_rd_q   [DEPTH];
    logic [DW-1:0] entry_data_q [DEPTH];

    logic          full;
    logic          empty;
    logic          mem_xfer;
    logic          alu_xfer;
    logic          push;
    logic          pop;
    logic [RW-1:0] push_rd;
    logic [DW-1:0] push_data;
    logic [AW-1:0] fwd_idx;

    // Status flags come from registered count only
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Load has fixed priority over the ALU for the single push slot
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_xfer  = mem_valid && mem_ready;
    assign alu_xfer  = alu_valid && alu_ready;

    // Select the accepted offer; writes to x0 are accepted but dropped
    always_comb begin
        push_rd   = '0;
        push_data = '0;
        if (mem_xfer) begin
            push_rd   = mem_rd;
            push_data = mem_data;
        end else if (alu_xfer) begin
            push_rd   = alu_rd;
            push_data = alu_data;
        end
    end

    assign push = (mem_xfer || alu_xfer) && (push_rd != '0);

    // Register-file write port presents the head entry
    assign we  = !empty && !wb_stall;
    assign rd  = empty ? '0 : entry_rd_q[head_q];
    assign wd  = empty ? '0 : entry_data_q[head_q];
    assign pop = we;

    assign count = count_q;

    // Next-state for pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer / occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the tail; reset suppresses a same-cycle transfer
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            entry_rd_q[tail_q]   <= push_rd;
            entry_data_q[tail_q] <= push_data;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fwd_idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && (fwd_rs != '0) &&
                (entry_rd_q[fwd_idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data_q[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset state, single write, priority,
// x0 discard, full/stall with wrap-around, forwarding, mid-operation reset.
module tb_writeback_queue;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        wb_stall;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    int checks;
    int failures;

    writeback_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wb_stall  (wb_stall),
        .we        (we),
        .rd        (rd),
        .wd        (wd),
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    task automatic check_wb(input string tag, input logic exp_we,
                            input logic [4:0] exp_rd, input logic [31:0] exp_wd);
        check({tag, "_we"}, 32'(we), 32'(exp_we));
        check({tag, "_rd"}, 32'(rd), 32'(exp_rd));
        check({tag, "_wd"}, wd, exp_wd);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        wb_stall  = 1'b0;
        fwd_rs    = '0;

        // Reset state
        tick();
        tick();
        settle();
        check_wb("rst_during", 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        fwd_rs = 5'd1;
        settle();
        check_wb("rst_after", 1'b0, 5'd0, 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst_fwd_data", fwd_data, 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);

        // Single ALU write
        tick();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd42;
        settle();
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        check("single_not_visible", 32'(we), 32'd0);
        tick();
        alu_valid = 1'b0;
        settle();
        check_wb("single_wr", 1'b1, 5'd1, 32'd42);
        check("single_count", 32'(count), 32'd1);
        check("single_fwd_hit", 32'(fwd_hit), 32'd1);
        check("single_fwd_data", fwd_data, 32'd42);
        tick();
        settle();
        check("single_done_we", 32'(we), 32'd0);
        check("single_done_count", 32'(count), 32'd0);

        // Load priority over ALU
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        settle();
        check("prio_mem_ready", 32'(mem_ready), 32'd1);
        check("prio_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        settle();
        check_wb("prio_first", 1'b1, 5'd3, 32'h11);
        check("prio_alu_ready2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        settle();
        check_wb("prio_second", 1'b1, 5'd4, 32'h22);
        check("prio_count", 32'(count), 32'd1);
        tick();
        settle();
        check("prio_done_we", 32'(we), 32'd0);

        // Destination x0 is accepted and dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        fwd_rs = 5'd0;
        settle();
        check("x0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        settle();
        check("x0_count", 32'(count), 32'd0);
        check("x0_we", 32'(we), 32'd0);
        check("x0_fwd_hit", 32'(fwd_hit), 32'd0);
        tick();
        settle();
        check("x0_we_later", 32'(we), 32'd0);

        // Fill under stall (pointers now wrap), then drain in order
        wb_stall = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h100 + 32'(i);
            tick();
        end
        alu_rd = 5'd9; alu_data = 32'h109;
        settle();
        check("full_count", 32'(count), 32'd4);
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        check("full_we", 32'(we), 32'd0);
        tick();
        settle();
        check("full_held_count", 32'(count), 32'd4);
        wb_stall = 1'b0;
        settle();
        check_wb("drain_5", 1'b1, 5'd5, 32'h105);
        check("drain_no_bypass", 32'(alu_ready), 32'd0);
        tick();
        settle();
        check("drain_count3", 32'(count), 32'd3);
        check("drain_alu_ready", 32'(alu_ready), 32'd1);
        check_wb("drain_6", 1'b1, 5'd6, 32'h106);
        tick();
        alu_valid = 1'b0;
        settle();
        check("drain_push_pop_count", 32'(count), 32'd3);
        check_wb("drain_7", 1'b1, 5'd7, 32'h107);
        tick();
        settle();
        check_wb("drain_8", 1'b1, 5'd8, 32'h108);
        tick();
        settle();
        check_wb("drain_9", 1'b1, 5'd9, 32'h109);
        tick();
        settle();
        check("drain_empty_we", 32'(we), 32'd0);
        check("drain_empty_count", 32'(count), 32'd0);

        // Forwarding returns the youngest match
        wb_stall = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd7;
        tick();
        alu_data = 32'd9;
        tick();
        alu_valid = 1'b0;
        fwd_rs = 5'd2;
        settle();
        check("fwd_count", 32'(count), 32'd2);
        check("fwd_hit_two", 32'(fwd_hit), 32'd1);
        check("fwd_data_two", fwd_data, 32'd9);
        fwd_rs = 5'd3;
        settle();
        check("fwd_miss_hit", 32'(fwd_hit), 32'd0);
        check("fwd_miss_data", fwd_data, 32'd0);
        fwd_rs = 5'd2;
        wb_stall = 1'b0;
        settle();
        check_wb("fwd_pop1", 1'b1, 5'd2, 32'd7);
        tick();
        settle();
        check("fwd_hit_one", 32'(fwd_hit), 32'd1);
        check("fwd_data_one", fwd_data, 32'd9);
        check_wb("fwd_pop2", 1'b1, 5'd2, 32'd9);
        tick();
        settle();
        check("fwd_hit_none", 32'(fwd_hit), 32'd0);
        check("fwd_data_none", fwd_data, 32'd0);

        // Reset mid-operation discards pending entries and a same-cycle offer
        wb_stall = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h200 + 32'(i);
            tick();
        end
        alu_valid = 1'b0;
        fwd_rs = 5'd10;
        settle();
        check("mrst_count_before", 32'(count), 32'd3);
        check("mrst_fwd_before", 32'(fwd_hit), 32'd1);
        rst = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'h213;
        tick();
        rst = 1'b0;
        mem_valid = 1'b0;
        settle();
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_we", 32'(we), 32'd0);
        check("mrst_fwd_hit", 32'(fwd_hit), 32'd0);
        fwd_rs = 5'd13;
        settle();
        check("mrst_fwd_discard", 32'(fwd_hit), 32'd0);
        wb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("mrst_no_stale_%0d", i), 32'(we), 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-write entries (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_valid  input  1  load unit offers a result.
REQ-005 mem_rd  input  5  load destination register.
REQ-006 mem_data  input  32  load result.
REQ-007 mem_ready  output  1  queue accepts mem offer this cycle.
REQ-008 alu_valid  input  1  ALU offers a result.
REQ-009 alu_rd  input  5  ALU destination register.
REQ-010 alu_data  input  32  ALU result.
REQ-011 alu_ready  output  1  queue accepts ALU offer this cycle.
REQ-012 wb_stall  input  1  regfile write port unavailable; hold head.
REQ-013 we  output  1  regfile write enable.
REQ-014 rd  output  5  regfile write address.
REQ-015 wd  output  32  regfile write data.
REQ-016 fwd_rs  input  5  register number looked up by decode.
REQ-017 fwd_hit  output  1  a pending entry targets fwd_rs.
REQ-018 fwd_data  output  32  data of youngest pending entry targeting fwd_rs.
REQ-019 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-020 Storage shall be a circular FIFO of DEPTH entries {rd, data}, with head/tail pointers that wrap modulo DEPTH.
REQ-021 full = (count == DEPTH); empty = (count == 0); both derived from registered count only.
REQ-022 mem_ready = !full; alu_ready = !full && !mem_valid (load has fixed priority).
REQ-023 A transfer occurs when valid && ready; at most one push per cycle.
REQ-024 A transfer with destination 0 is accepted (ready honoured) but not enqueued; count unchanged by it.
REQ-025 A pushed entry is written at the tail on the clock edge of the transfer and is first visible on we/rd/wd and forwarding the following cycle.
REQ-026 we = !empty && !wb_stall; rd/wd = head entry when !empty, else 0.
REQ-027 Pop occurs on an edge where we = 1; head advances by one.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 When full, push is refused even if a pop occurs that cycle (no same-cycle full-bypass).
REQ-030 Write order to the regfile equals acceptance order; no entry is reordered, merged or dropped (except rd = 0 per REQ-024).
REQ-031 fwd_hit = 1 iff fwd_rs != 0 and any valid entry (including head) has rd == fwd_rs; combinational on stored state only, excluding any same-cycle incoming offer.
REQ-032 fwd_data = data of the youngest (nearest tail) matching entry; 0 when fwd_hit = 0.
REQ-033 wb_stall only suppresses pop; pushes continue until full.

Reset
REQ-034 On rst high at a rising edge: head, tail, count cleared to 0; entry contents need not be cleared.
REQ-035 During and after reset until a push: we = 0, rd = 0, wd = 0, fwd_hit = 0, fwd_data = 0, mem_ready = alu_ready = 1 (subject to REQ-022).
REQ-036 rst asserted with a transfer in the same cycle: reset wins; transfer is discarded.

Verification
REQ-037 Single ALU write: alu rd=1 data=42 for one cycle -> next cycle we=1, rd=1, wd=42; following cycle we=0, count=0.
REQ-038 Priority: mem (rd=3, 0x11) and alu (rd=4, 0x22) valid together -> mem_ready=1, alu_ready=0; writes appear in order rd=3 then rd=4 after alu re-offers.
REQ-039 x0 discard: alu rd=0 data=0xFFFF_FFFF accepted -> count stays 0, we never asserts, fwd_rs=0 gives fwd_hit=0.
REQ-040 Full/stall: wb_stall=1, push rd=5..8 -> count=4, both readies 0; fifth offer held; release stall -> four writes rd=5,6,7,8 on consecutive cycles, then held offer enqueued.
REQ-041 Forwarding: stall, push rd=2 data=7 then rd=2 data=9 -> fwd_rs=2 gives fwd_hit=1, fwd_data=9; after first pop still 9; after second pop fwd_hit=0.
REQ-042 Reset mid-operation: three entries pending under stall, assert rst one cycle -> count=0, we=0, fwd_hit=0; no stale write appears after release.
